mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single core memory port between instruction fetch (IF) and load/store (LSU) requesters. It accepts one request at a time and issues it on the downstream valid/ready request channel. It then routes the single outstanding response back to the owner, returning an error response if the memory does not answer within a bounded time. It sits between the CPU's `if_*`/`mem_*` interfaces and the pmem/CLINT bus, replacing the per-port direct DPI accesses.

## Interface
- `ADDR_WIDTH`, 64, address width
- `DATA_WIDTH`, 64, memory data width
- `INST_WIDTH`, 32, instruction width returned to IF
- `TIMEOUT`, 255, maximum response wait in cycles (1..255); held in an 8-bit counter
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-low reset: 0 resets all state immediately; release is synchronous to `clk` upstream
- `if_req_valid`  in  1  IF fetch request
- `if_req_ready`  out  1  IF request accepted this cycle
- `if_addr`  in  ADDR_WIDTH  fetch address; bit 2 selects word
- `if_rsp_valid`  out  1  fetch response, one-cycle pulse
- `if_rsp_data`  out  INST_WIDTH  instruction
- `if_rsp_err`  out  1  fetch timed out
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_ready`  out  1  LSU request accepted
- `lsu_addr`  in  ADDR_WIDTH  data address
- `lsu_wen`  in  1  1 = write
- `lsu_wdata`  in  DATA_WIDTH  write data
- `lsu_wmask`  in  8  byte mask
- `lsu_rsp_valid`  out  1  LSU response pulse; also acknowledges writes
- `lsu_rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes
- `lsu_rsp_err`  out  1  LSU access timed out
- `mem_req_valid`  out  1  downstream request
- `mem_req_ready`  in  1  downstream accepts
- `mem_addr`  out  ADDR_WIDTH
- `mem_wen`  out  1
- `mem_wdata`  out  DATA_WIDTH
- `mem_wmask`  out  8  0x00 for IF reads
- `mem_rsp_valid`  in  1  downstream response; always accepted
- `mem_rsp_data`  in  DATA_WIDTH

## Operation
- States: IDLE, REQ, WAIT. Reset: IDLE, `last_grant`=IF, `owner`=IF, timeout counter 0, latched request registers 0.
- IDLE grant, combinational:
  - only one requester valid: grant it;
  - both valid: grant the one opposite `last_grant`, i.e. round-robin;
  - `*_req_ready` = (state==IDLE) & grant; at most one is high.
- On handshake: latch address, wen, wdata, wmask, `owner` and `last_grant`; go to REQ.
  - IF latches wen=0, wmask=0x00, wdata=0.
- REQ: `mem_req_valid`=1 with the `mem_*` fields driven from the latched registers and stable until accepted. On `mem_req_ready`: go to WAIT, clear counter.
- WAIT: counter increments each cycle without `mem_rsp_valid`.
  - `mem_rsp_valid`: pulse `owner`'s rsp_valid with err=0 and go to IDLE.
  - Counter reaches TIMEOUT first: pulse `owner`'s rsp_valid with err=1, data 0, and go to IDLE.
- Response data:
  - IF: `mem_rsp_data[63:32]` if latched addr[2]=1, else `[31:0]`.
  - LSU read: full word.
  - LSU write: 0.
- `mem_rsp_valid` in IDLE or REQ, including a late response after timeout, is ignored.
- The non-owner's rsp_valid is never asserted.

## Timing
- Reset values: all `*_ready`, `*_rsp_valid`, `*_rsp_err`, `mem_req_valid` = 0; all data/address outputs 0.
- Response outputs are combinational from `mem_rsp_valid` in WAIT, or registered on the timeout cycle.
- Minimum transaction:
  - cycle 0: requester handshake;
  - cycle 1: `mem_req_valid`, accepted;
  - cycle 2: response pulse;
  - cycle 3: next requester handshake.
  - Throughput is one access per 3 cycles.
- Timeout response arrives exactly TIMEOUT cycles after entering WAIT.
- Requester valid may drop at any time without handshake; no state change results.
- Reset asserted mid-transaction: immediate return to IDLE, no response pulse, pending access abandoned.

## Test plan
- Reset: hold `rst`=0 with both requesters valid -> all outputs 0. Release -> IF-only request at 0x80000000 is granted the first IDLE cycle; `mem_addr`=0x80000000, `mem_wmask`=0x00.
- IF word select: fetch 0x80000004, `mem_rsp_data`=0x00000013_00100073 in the cycle after request acceptance -> `if_rsp_data`=0x00000013, pulse 1 cycle; fetch 0x80000000 returns 0x00100073.
- Contention: both valid every cycle for 6 transactions -> grants alternate LSU, IF, LSU, IF, LSU, IF. No cycle has both readies high.
- LSU write: addr 0x80001000, wdata 0x1122334455667788, wmask 0x0F; `mem_req_ready` delayed 3 cycles -> `mem_*` fields stable while waiting; `lsu_rsp_valid`=1, rdata 0.
- Timeout with TIMEOUT=4: LSU read with no `mem_rsp_valid` -> `lsu_rsp_err`=1 exactly 4 cycles after WAIT entry. A late `mem_rsp_valid` afterwards produces no response pulse.
- Reset mid-WAIT: assert `rst`=0 during WAIT -> immediate IDLE, no rsp pulse. After release, the next request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - bundle of IF/LSU requester channels and the shared downstream memory channel
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_rsp_valid;
    logic [INST_WIDTH-1:0] if_rsp_data;
    logic                  if_rsp_err;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic                  lsu_wen;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic [7:0]            lsu_wmask;
    logic                  lsu_rsp_valid;
    logic [DATA_WIDTH-1:0] lsu_rsp_rdata;
    logic                  lsu_rsp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [7:0]            mem_wmask;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin IF/LSU arbiter onto one memory port with one outstanding access and response timeout
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_LSU} owner_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_grant_q, last_grant_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wmask_q, wmask_d;

    logic grant_if, grant_lsu;
    logic if_hs, lsu_hs;
    logic timed_out, rsp_hit, rsp_fire;

    // Under contention the requester that did not win last time gets the port.
    always_comb begin
        grant_if  = 1'b0;
        grant_lsu = 1'b0;
        if (bus.if_req_valid && bus.lsu_req_valid) begin
            grant_lsu = (last_grant_q == OWN_IF);
            grant_if  = ~grant_lsu;
        end else begin
            grant_if  = bus.if_req_valid;
            grant_lsu = bus.lsu_req_valid;
        end
    end

    // rst gates the readies so nothing is offered while reset is held.
    assign if_hs  = (state_q == S_IDLE) && grant_if  && rst;
    assign lsu_hs = (state_q == S_IDLE) && grant_lsu && rst;

    assign timed_out = (state_q == S_WAIT) && (cnt_q == TIMEOUT_CNT);
    assign rsp_hit   = (state_q == S_WAIT) && !timed_out && bus.mem_rsp_valid;
    assign rsp_fire  = timed_out || rsp_hit;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        case (state_q)
            S_IDLE: begin
                if (if_hs || lsu_hs) begin
                    owner_d      = lsu_hs ? OWN_LSU : OWN_IF;
                    last_grant_d = lsu_hs ? OWN_LSU : OWN_IF;
                    addr_d       = lsu_hs ? bus.lsu_addr : bus.if_addr;
                    wen_d        = lsu_hs && bus.lsu_wen;
                    wdata_d      = lsu_hs ? bus.lsu_wdata : '0;
                    wmask_d      = lsu_hs ? bus.lsu_wmask : 8'h00;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (rsp_fire) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            cnt_q        <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

    assign bus.if_req_ready  = if_hs;
    assign bus.lsu_req_ready = lsu_hs;

    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;

    assign bus.if_rsp_valid  = rsp_fire && (owner_q == OWN_IF);
    assign bus.if_rsp_err    = timed_out && (owner_q == OWN_IF);
    assign bus.lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
    assign bus.lsu_rsp_err   = timed_out && (owner_q == OWN_LSU);

    // Address bit 2 picks which 32-bit half of the memory word holds the instruction.
    assign bus.if_rsp_data = (rsp_hit && (owner_q == OWN_IF))
                           ? (addr_q[2] ? bus.mem_rsp_data[INST_WIDTH +: INST_WIDTH]
                                        : bus.mem_rsp_data[INST_WIDTH-1:0])
                           : '0;

    assign bus.lsu_rsp_rdata = (rsp_hit && (owner_q == OWN_LSU) && !wen_q)
                             ? bus.mem_rsp_data : '0;
endmodule
